// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Multi-cycle load/store unit sitting between the core's address/rs2 path and
//   a handshaked data memory port. The core is held with stall_o while an
//   access is in flight. Stores get byte enables and lane-replicated data;
//   loads return aligned, sign- or zero-extended data. Illegal, trapped
//   misaligned and timed-out accesses finish with a one-cycle err_o pulse.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned LH/LHU/SH/LW/SW are rejected through the error state
//     undefined : misaligned halfword/word accesses are forced to alignment
//
//   Ports
//     clk_i, reset_i          clock, asynchronous active-high reset
//     req_valid_i, ld_i, st_i access request and its direction
//     fun_3_i                 size/sign field (instr[14:12])
//     addr_i, wdata_i         byte address and store data
//     stall_o                 hold the core's PC
//     done_o, err_o, rdata_o  completion pulse, error pulse, extended load data
//     mem_req_o .. mem_wdata_o memory request side (registered)
//     mem_ack_i, mem_rdata_i  memory acknowledge and read word
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   input  logic        ld_i,
   input  logic        st_i,
   input  logic [2:0]  fun_3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q;
   logic [2:0]  fun_3_q;
   logic [1:0]  off_q;
   logic [31:0] rdata_q;
   logic        mem_req_q, mem_we_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [3:0]  mem_be_q;

   logic        access_s, illegal_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;

   // Select the addressed byte/half from the read word and extend it.
   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h000000, b};
         3'b101:  return {16'h0000, h};
         default: return w;
      endcase
   endfunction

   assign access_s = req_valid_i & (ld_i | st_i);

   // Legality of the presented access (opcode encoding and optional alignment trap).
   always_comb begin
      illegal_s = 1'b0;
      if (ld_i && st_i) begin
         illegal_s = 1'b1;
      end else if (ld_i) begin
         case (fun_3_i)
            3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
            default:                illegal_s = 1'b0;
         endcase
      end else if (st_i) begin
         illegal_s = (fun_3_i > 3'b010);
      end else begin
         illegal_s = 1'b0;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      if ((fun_3_i[1:0] == 2'b01) && addr_i[0]) begin
         illegal_s = 1'b1;
      end else if ((fun_3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) begin
         illegal_s = 1'b1;
      end else begin
         illegal_s = illegal_s;
      end
`endif
   end

   // Byte enables and lane replication; misaligned halves/words are forced aligned.
   always_comb begin
      case (fun_3_i[1:0])
         2'b00: begin
            be_s    = 4'b0001 << addr_i[1:0];
            wdata_s = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_s    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{wdata_i[15:0]}};
         end
         default: begin
            be_s    = 4'b1111;
            wdata_s = wdata_i;
         end
      endcase
      if (ld_i) begin
         be_s = 4'b1111;
      end else begin
         be_s = be_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; an ack on the timeout edge takes priority.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (access_s) begin
               state_d = illegal_s ? ST_ERR : ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_ack_i) begin
               state_d = ST_RESP;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = ST_ERR;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from the state register.
   always_comb begin
      stall_o = (state_q == ST_REQ) || (state_q == ST_ERR) ||
                ((state_q == ST_IDLE) && access_s);
      done_o  = (state_q == ST_RESP) || (state_q == ST_ERR);
      err_o   = (state_q == ST_ERR);
   end

   // Request latch, timeout counter and load data capture.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q       <= 8'd0;
         fun_3_q     <= 3'd0;
         off_q       <= 2'd0;
         rdata_q     <= 32'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'd0;
         mem_wdata_q <= 32'd0;
      end else begin
         mem_req_q <= (state_d == ST_REQ);
         if (state_q != ST_REQ) begin
            cnt_q <= 8'd0;
         end else if (state_d == ST_REQ) begin
            cnt_q <= cnt_q + 8'd1;
         end else begin
            cnt_q <= cnt_q;
         end
         if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            fun_3_q     <= fun_3_i;
            off_q       <= addr_i[1:0];
            mem_we_q    <= st_i;
            mem_addr_q  <= {addr_i[31:2], 2'b00};
            mem_be_q    <= be_s;
            mem_wdata_q <= wdata_s;
         end
         if ((state_q == ST_REQ) && mem_ack_i && !mem_we_q) begin
            rdata_q <= load_ext(fun_3_q, off_q, mem_rdata_i);
         end else if (state_d == ST_ERR) begin
            rdata_q <= 32'd0;
         end else begin
            rdata_q <= rdata_q;
         end
      end
   end

   assign rdata_o     = rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_be_o    = mem_be_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core's ALU address/rs2 path and a handshaked data memory port. It holds the core with `stall` while an access is in flight. It generates byte enables and replicated write data for SB/SH/SW. It returns aligned, sign- or zero-extended load data for LB/LH/LW/LBU/LHU, and reports illegal, misaligned or timed-out accesses on `err`.

## Interface
- `TIMEOUT`, 15: maximum consecutive REQ-state cycles without `mem_ack` before the access is abandoned. Range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: core presents an access. Held stable by the core while `stall`=1.
- `ld` in 1: load request.
- `st` in 1: store request.
- `fun_3` in 3: instr[14:12]. Size and sign.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `stall` out 1: core must not advance the PC.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load data, valid while `done`=1.
- `err` out 1: one-cycle error pulse, coincident with `done`.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables; lane i = bits [8i+7:8i].
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory accepted the write or returned read data this cycle.
- `mem_rdata` in 32: read word, sampled when `mem_ack`=1.

## Operation
- States: IDLE, REQ, RESP, ERR. Encoding is free; the state machine is registered.
- IDLE:
  - With `req_valid`=1 and exactly one of `ld`/`st` set, and a legal, permitted access: latch `addr`, `fun_3`, `mem_be`, `mem_wdata` and `mem_we`. Go to REQ.
  - With `req_valid`=1 and an illegal access: go to ERR and issue no memory request.
  - With `req_valid`=0, or `ld`=`st`=0: stay in IDLE. This is not an error.
- Illegal accesses:
  - `ld` and `st` both set.
  - Load `fun_3` in {011, 110, 111}.
  - Store `fun_3` not in {000, 001, 010}.
  - A misaligned access, when trapped (see Configuration).
- REQ:
  - `mem_req`=1 with all `mem_*` outputs stable.
  - On `mem_ack`=1: capture the extended `mem_rdata` into `rdata` (loads only) and go to RESP.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT`, go to ERR and drop `mem_req`.
- RESP: `done`=1 for one cycle, then go to IDLE. A request present in RESP is not accepted until the following IDLE cycle.
- ERR: `done`=1, `err`=1 and `rdata`=0 for one cycle, then go to IDLE.
- Store lanes:
  - SB: `be`=1<<addr[1:0]; `wdata[7:0]` replicated to all 4 lanes.
  - SH: `be`=addr[1] ? 1100 : 0011; `wdata[15:0]` replicated to both halves.
  - SW: `be`=1111.
- Loads:
  - Select a byte by addr[1:0] or a half by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Loads drive `mem_be`=1111 and `mem_we`=0.
- `stall`:
  - 1 in REQ and ERR.
  - 1 in IDLE when `req_valid`&(`ld`|`st`).
  - 0 in RESP and otherwise.
- A `mem_ack` arriving outside REQ is ignored.

## Timing
- Reset values: state IDLE; `stall`, `done`, `err`, `mem_req`, `mem_we` = 0; `rdata`, `mem_addr`, `mem_be`, `mem_wdata` = 0; timeout counter = 0.
- Reset asserted mid-access drops `mem_req` immediately (asynchronously) and abandons the access.
- Latency: request accepted at edge N, so `mem_req`=1 from N. If `mem_ack` is sampled at edge N+k (k≥1), `done` is high from N+k to N+k+1.
- Zero-wait memory gives 2 cycles of stall in total.
- Timeout: counter clears on entry to REQ. If `mem_ack`=1 on the same edge the counter hits `TIMEOUT`, the ack wins and the access completes.
- Illegal access: `err`/`done` are high during the cycle after acceptance. `mem_req` never rises.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Trapped misaligned accesses are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0.
  - Such an access goes to ERR with no memory request.
- Not defined:
  - Misaligned accesses are forced aligned. Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - The access proceeds normally and `err` never asserts for misalignment.

## Test plan
- LW at addr 0x100; `mem_ack` in the first REQ cycle with `mem_rdata`=0xDEADBEEF. Required: `mem_addr`=0x100, `be`=1111, `done` 2 cycles after acceptance, `rdata`=0xDEADBEEF.
- LB at 0x103 with `mem_rdata`=0x80FF_0000 → `rdata`=0xFFFFFF80. LBU, same inputs → `rdata`=0x00000080. LHU at 0x102 → `rdata`=0x000080FF.
- SB at 0x101 with `wdata`=0x12345678. Required: `mem_we`=1, `be`=0010, `mem_wdata`=0x78787878. SH at 0x102 → `be`=1100, `mem_wdata`=0x56785678.
- `mem_ack` held low with `TIMEOUT`=15. Required: `mem_req` high for exactly 15 cycles, then `err`=`done`=1 for one cycle, then IDLE. A later `mem_ack` is ignored.
- LW at 0x102. With `LSU_MISALIGN_TRAP_EN`: `err` pulse and `mem_req` stays 0. Without it: `mem_addr`=0x100 and normal completion. Also `ld`=`st`=1 → `err` in both builds.
- `reset` pulsed during REQ of a store. Required: `mem_req` goes to 0 without waiting for `clk`, all outputs return to reset values, and the next LW completes normally.
